pong_engine: RTL and testbench
==============================

PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- PADDLE_H, 40: paddle height in lines.
- PADDLE_STEP, 2: paddle movement in lines per tick.
- BALL_SIZE, 8: ball edge length in pixels.
- BALL_SPEED, 2: ball movement in pixels per axis per tick.
- TOP, 34: first playfield line.
- BOTTOM, 516: last playfield line.
- H_MIN, 144: left miss boundary, in pixels.
- H_MAX, 783: right miss boundary, in pixels.
- L_X0, 150: left paddle, left edge.
- L_X1, 170: left paddle, right edge.
- R_X0, 757: right paddle, left edge.
- R_X1, 777: right paddle, right edge.
- WIN_SCORE, 7: points that end the game.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst, in, 1: reset, synchronous and active-low.
- tick, in, 1: one-cycle motion enable, one pulse per frame.
- up1, in, 1: player 1 up.
- down1, in, 1: player 1 down.
- up2, in, 1: player 2 up.
- down2, in, 1: player 2 down.
- serve, in, 1: serve or restart request.
- bright, in, 1: visible-area flag.
- hCount, in, 10: pixel column.
- vCount, in, 10: pixel line.
- rgb, out, 12: pixel colour, combinational.
- score, out, 16: [15:8] is P1, [7:0] is P2, unsigned binary.
- game_over, out, 1: high while in state OVER.

Function
REQ-003 All registers SHALL update only on the rising edge of clk, and positions SHALL change only in cycles where tick=1.
REQ-004 The FSM SHALL have the states IDLE, PLAY, POINT and OVER, with these transitions:
- IDLE to PLAY on serve=1.
- PLAY to POINT on a miss.
- POINT to OVER if the updated score equals WIN_SCORE, otherwise POINT to IDLE, both after exactly one cycle.
- OVER to IDLE on serve=1; scores clear to 0 on this transition.
REQ-005 Paddle centres py1 and py2 SHALL move by PADDLE_STEP on tick in IDLE and PLAY, and hold in POINT and OVER.
REQ-006 A paddle SHALL not move when its up and down inputs are both 1.
REQ-007 Paddle centres SHALL saturate to [TOP+PADDLE_H/2, BOTTOM-PADDLE_H/2], and a step that would overshoot SHALL land exactly on the limit.
REQ-008 The ball SHALL be tracked as its top-left corner (bx, by) with direction bits dx (1 = right) and dy (1 = down), and SHALL move only in PLAY on tick.
REQ-009 Wall bounce SHALL work as follows:
- Moving up with by-BALL_SPEED <= TOP: set by=TOP and dy=1.
- Moving down with by+BALL_SIZE-1+BALL_SPEED >= BOTTOM: set by=BOTTOM-BALL_SIZE+1 and dy=0.
REQ-010 Left paddle hit SHALL be detected when dx=0, bx-BALL_SPEED <= L_X1, bx >= L_X0, and the vertical span [by, by+BALL_SIZE-1] overlaps [py1-PADDLE_H/2, py1+PADDLE_H/2]; the response SHALL be bx=L_X1+1 and dx=1.
REQ-011 Right paddle hit SHALL mirror REQ-010 with the right paddle: the response SHALL be bx=R_X0-BALL_SIZE and dx=0.
REQ-012 When a wall bounce and a paddle hit occur on the same tick, both SHALL be applied.
REQ-013 A miss SHALL be detected as follows:
- Left miss: dx=0 and bx-BALL_SPEED <= H_MIN without a hit; P2 scores.
- Right miss: dx=1 and bx+BALL_SIZE-1+BALL_SPEED >= H_MAX without a hit; P1 scores.
REQ-014 In POINT, the scorer's count SHALL increment by 1 and the ball SHALL re-centre to bx=460, by=271. The next serve SHALL travel toward the player who conceded, with dy=1.
REQ-015 Scores SHALL never exceed WIN_SCORE.
REQ-016 serve SHALL be ignored in PLAY and POINT.
REQ-017 serve and tick asserted in the same IDLE cycle SHALL cause the transition only, with no ball motion in that cycle.
REQ-018 rgb SHALL use this priority order:
- ~bright: BLACK (000).
- Ball pixel, when not in OVER: RED (F00).
- Paddle pixel: GREEN (0F0).
- Midline, hCount 318..322 and vCount TOP..BOTTOM: WHITE (FFF).
- Background: BLUE (00F), or RED (F00) in OVER.
REQ-019 All arithmetic SHALL use 11-bit intermediates so that subtraction near 0 cannot wrap.

Reset
REQ-020 With rst=0 at a clock edge, the block SHALL enter IDLE and set:
- py1 = py2 = 275.
- bx=460, by=271.
- dx=1, dy=1.
- score=16'h0000, game_over=0.
REQ-021 Reset SHALL override every other input, including a reset that arrives mid-PLAY or mid-POINT.

Verification
REQ-022 Paddle clamp: with up1=1 held for 200 ticks from reset, py1 = 54 and remains 54.
REQ-023 Top wall: in PLAY with by=35, dy=0 and a tick, the result is by=34 and dy=1.
REQ-024 Left hit: with bx=171, dx=0, by=py1-4 and a tick, the result is bx=171 and dx=1, with the score unchanged.
REQ-025 Left miss: with the left paddle away from the ball and bx=145, dx=0, a tick yields POINT, then score=16'h0001, then IDLE with the ball centred and dx=0.
REQ-026 Game end: with score[15:8]=6, a right miss yields score=16'h0700, game_over=1 and rgb background F00; serve then yields score=0 and IDLE.
REQ-027 Reset mid-play: rst=0 during PLAY yields the REQ-020 values on the next edge, and a simultaneous serve is ignored.

Source files
------------

// File: rtl/pong_engine.sv
// Two-player pong core: paddle and ball motion, wall/paddle bounce, scoring FSM and
// a combinational pixel colour for the current raster position.
module pong_engine #(
  parameter int unsigned PADDLE_H    = 40,
  parameter int unsigned PADDLE_STEP = 2,
  parameter int unsigned BALL_SIZE   = 8,
  parameter int unsigned BALL_SPEED  = 2,
  parameter int unsigned TOP         = 34,
  parameter int unsigned BOTTOM      = 516,
  parameter int unsigned H_MIN       = 144,
  parameter int unsigned H_MAX       = 783,
  parameter int unsigned L_X0        = 150,
  parameter int unsigned L_X1        = 170,
  parameter int unsigned R_X0        = 757,
  parameter int unsigned R_X1        = 777,
  parameter int unsigned WIN_SCORE   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        up1,
  input  logic        down1,
  input  logic        up2,
  input  logic        down2,
  input  logic        serve,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [11:0] rgb,
  output logic [15:0] score,
  output logic        game_over
);

  localparam logic [10:0] LP_HALF   = 11'(PADDLE_H / 2);
  localparam logic [10:0] LP_STEP   = 11'(PADDLE_STEP);
  localparam logic [10:0] LP_SIZE   = 11'(BALL_SIZE);
  localparam logic [10:0] LP_SPD    = 11'(BALL_SPEED);
  localparam logic [10:0] LP_TOP    = 11'(TOP);
  localparam logic [10:0] LP_BOTTOM = 11'(BOTTOM);
  localparam logic [10:0] LP_HMIN   = 11'(H_MIN);
  localparam logic [10:0] LP_HMAX   = 11'(H_MAX);
  localparam logic [10:0] LP_LX0    = 11'(L_X0);
  localparam logic [10:0] LP_LX1    = 11'(L_X1);
  localparam logic [10:0] LP_RX0    = 11'(R_X0);
  localparam logic [10:0] LP_RX1    = 11'(R_X1);
  localparam logic [10:0] LP_PY_MIN = 11'(TOP + PADDLE_H / 2);
  localparam logic [10:0] LP_PY_MAX = 11'(BOTTOM - PADDLE_H / 2);
  localparam logic [10:0] LP_PY_RST = 11'd275;
  localparam logic [10:0] LP_BX_C   = 11'd460;
  localparam logic [10:0] LP_BY_C   = 11'd271;
  localparam logic [7:0]  LP_WIN    = 8'(WIN_SCORE);

  typedef enum logic [1:0] {StIdle, StPlay, StPoint, StOver} state_t;

  state_t      r_state;
  logic [10:0] r_py1, r_py2, r_bx, r_by;
  logic        r_dx, r_dy, r_p1_scored;
  logic [7:0]  r_s1, r_s2;

  logic [10:0] w_py1_n, w_py2_n, w_bx_n, w_by_n, w_h, w_v;
  logic        w_dx_n, w_dy_n, w_ov_l, w_ov_r, w_hit_l, w_hit_r, w_miss_l, w_miss_r;
  logic        w_ball_px, w_pad_px, w_mid_px;
  logic [7:0]  w_s1_inc, w_s2_inc;

  function automatic logic [10:0] f_paddle(input logic [10:0] py, input logic up,
                                           input logic dn);
    logic [10:0] v;
    v = py;
    if (up && !dn)      v = (py < LP_PY_MIN + LP_STEP) ? LP_PY_MIN : py - LP_STEP;
    else if (dn && !up) v = (py + LP_STEP > LP_PY_MAX) ? LP_PY_MAX : py + LP_STEP;
    return v;
  endfunction

  // Comparisons are rearranged as additions so nothing is ever subtracted below zero.
  always_comb begin
    w_py1_n  = f_paddle(r_py1, up1, down1);
    w_py2_n  = f_paddle(r_py2, up2, down2);
    w_ov_l   = (r_by <= r_py1 + LP_HALF) && (r_by + LP_SIZE - 11'd1 + LP_HALF >= r_py1);
    w_ov_r   = (r_by <= r_py2 + LP_HALF) && (r_by + LP_SIZE - 11'd1 + LP_HALF >= r_py2);
    w_hit_l  = !r_dx && (r_bx <= LP_LX1 + LP_SPD) && (r_bx >= LP_LX0) && w_ov_l;
    w_hit_r  = r_dx && (r_bx + LP_SIZE - 11'd1 + LP_SPD >= LP_RX0) &&
               (r_bx + LP_SIZE - 11'd1 <= LP_RX1) && w_ov_r;
    w_miss_l = !r_dx && (r_bx <= LP_HMIN + LP_SPD) && !w_hit_l;
    w_miss_r = r_dx && (r_bx + LP_SIZE - 11'd1 + LP_SPD >= LP_HMAX) && !w_hit_r;

    w_bx_n = r_dx ? r_bx + LP_SPD : r_bx - LP_SPD;
    w_dx_n = r_dx;
    if (w_hit_l) begin
      w_bx_n = LP_LX1 + 11'd1;
      w_dx_n = 1'b1;
    end else if (w_hit_r) begin
      w_bx_n = LP_RX0 - LP_SIZE;
      w_dx_n = 1'b0;
    end

    w_by_n = r_dy ? r_by + LP_SPD : r_by - LP_SPD;
    w_dy_n = r_dy;
    if (!r_dy && (r_by <= LP_TOP + LP_SPD)) begin
      w_by_n = LP_TOP;
      w_dy_n = 1'b1;
    end else if (r_dy && (r_by + LP_SIZE - 11'd1 + LP_SPD >= LP_BOTTOM)) begin
      w_by_n = LP_BOTTOM - LP_SIZE + 11'd1;
      w_dy_n = 1'b0;
    end

    w_s1_inc = (r_s1 < LP_WIN) ? r_s1 + 8'd1 : r_s1;
    w_s2_inc = (r_s2 < LP_WIN) ? r_s2 + 8'd1 : r_s2;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_py1       <= LP_PY_RST;
      r_py2       <= LP_PY_RST;
      r_bx        <= LP_BX_C;
      r_by        <= LP_BY_C;
      r_dx        <= 1'b1;
      r_dy        <= 1'b1;
      r_p1_scored <= 1'b0;
      r_s1        <= 8'd0;
      r_s2        <= 8'd0;
    end else begin
      if (tick && (r_state == StIdle || r_state == StPlay)) begin
        r_py1 <= w_py1_n;
        r_py2 <= w_py2_n;
      end
      unique case (r_state)
        StIdle: if (serve) r_state <= StPlay;
        StPlay: begin
          if (tick) begin
            if (w_miss_l || w_miss_r) begin
              r_state     <= StPoint;
              r_p1_scored <= w_miss_r;
            end else begin
              r_bx <= w_bx_n;
              r_by <= w_by_n;
              r_dx <= w_dx_n;
              r_dy <= w_dy_n;
            end
          end
        end
        StPoint: begin
          r_bx <= LP_BX_C;
          r_by <= LP_BY_C;
          r_dx <= r_p1_scored;  // serve toward whoever conceded
          r_dy <= 1'b1;
          if (r_p1_scored) begin
            r_s1    <= w_s1_inc;
            r_state <= (w_s1_inc == LP_WIN) ? StOver : StIdle;
          end else begin
            r_s2    <= w_s2_inc;
            r_state <= (w_s2_inc == LP_WIN) ? StOver : StIdle;
          end
        end
        StOver: begin
          if (serve) begin
            r_s1    <= 8'd0;
            r_s2    <= 8'd0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign score     = {r_s1, r_s2};
  assign game_over = (r_state == StOver);

  always_comb begin
    w_h       = {1'b0, hCount};
    w_v       = {1'b0, vCount};
    w_ball_px = (w_h >= r_bx) && (w_h < r_bx + LP_SIZE) &&
                (w_v >= r_by) && (w_v < r_by + LP_SIZE);
    w_pad_px  = ((w_h >= LP_LX0) && (w_h <= LP_LX1) &&
                 (w_v + LP_HALF >= r_py1) && (w_v <= r_py1 + LP_HALF)) ||
                ((w_h >= LP_RX0) && (w_h <= LP_RX1) &&
                 (w_v + LP_HALF >= r_py2) && (w_v <= r_py2 + LP_HALF));
    w_mid_px  = (w_h >= 11'd318) && (w_h <= 11'd322) && (w_v >= LP_TOP) && (w_v <= LP_BOTTOM);
    if (!bright)                         rgb = 12'h000;
    else if (w_ball_px && !game_over)    rgb = 12'hF00;
    else if (w_pad_px)                   rgb = 12'h0F0;
    else if (w_mid_px)                   rgb = 12'hFFF;
    else                                 rgb = game_over ? 12'hF00 : 12'h00F;
  end

endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: random rallies checked against a behavioural game model,
// observing the design through score, game_over and probed rgb pixels.
module tb_pong_engine;

  localparam int TOP = 34, BOTTOM = 516, HALF = 20, SIZE = 8, SPD = 2, STEP = 2;
  localparam int L_X0 = 150, L_X1 = 170, R_X0 = 757, R_X1 = 777;
  localparam int H_MIN = 144, H_MAX = 783, WIN = 7;
  localparam int PY_MIN = TOP + HALF, PY_MAX = BOTTOM - HALF;
  localparam int M_IDLE = 0, M_PLAY = 1, M_POINT = 2, M_OVER = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1, tick = 1'b0, serve = 1'b0, bright = 1'b1;
  logic        up1 = 1'b0, down1 = 1'b0, up2 = 1'b0, down2 = 1'b0;
  logic [9:0]  hCount = '0, vCount = '0;
  logic [11:0] rgb;
  logic [15:0] score;
  logic        game_over;

  int errors = 0, checks = 0;
  int m_st, m_py1, m_py2, m_bx, m_by, m_s1, m_s2;
  bit m_dx, m_dy, m_p1;

  pong_engine dut (
    .clk(clk), .rst(rst), .tick(tick), .up1(up1), .down1(down1), .up2(up2), .down2(down2),
    .serve(serve), .bright(bright), .hCount(hCount), .vCount(vCount),
    .rgb(rgb), .score(score), .game_over(game_over)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic bit overlap(input int a0, input int a1, input int b0, input int b1);
    return (a0 <= b1) && (b0 <= a1);
  endfunction

  function automatic int move(input int py, input bit up, input bit dn);
    return clampi(py - (up ? STEP : 0) + (dn ? STEP : 0), PY_MIN, PY_MAX);
  endfunction

  task automatic ball_tick();
    int lo, hi;
    bit hl, hr, ml, mr;
    lo = m_bx;
    hi = m_bx + SIZE - 1;
    hl = !m_dx && (lo - SPD <= L_X1) && (lo >= L_X0) &&
         overlap(m_by, m_by + SIZE - 1, m_py1 - HALF, m_py1 + HALF);
    hr = m_dx && (hi + SPD >= R_X0) && (hi <= R_X1) &&
         overlap(m_by, m_by + SIZE - 1, m_py2 - HALF, m_py2 + HALF);
    ml = !m_dx && (lo - SPD <= H_MIN) && !hl;
    mr = m_dx && (hi + SPD >= H_MAX) && !hr;
    if (ml || mr) begin
      m_st = M_POINT;
      m_p1 = mr;
      return;
    end
    if (hl)      begin m_bx = L_X1 + 1;   m_dx = 1; end
    else if (hr) begin m_bx = R_X0 - SIZE; m_dx = 0; end
    else m_bx = m_bx + (m_dx ? SPD : -SPD);
    if (!m_dy && m_by - SPD <= TOP)                     begin m_by = TOP; m_dy = 1; end
    else if (m_dy && m_by + SIZE - 1 + SPD >= BOTTOM)   begin m_by = BOTTOM - SIZE + 1; m_dy = 0; end
    else m_by = m_by + (m_dy ? SPD : -SPD);
  endtask

  task automatic model_update(input bit r, t, u1, d1, u2, d2, s);
    int n1, n2;
    if (!r) begin
      m_st = M_IDLE; m_py1 = 275; m_py2 = 275; m_bx = 460; m_by = 271;
      m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0; m_p1 = 0;
      return;
    end
    n1 = m_py1;
    n2 = m_py2;
    if (t && (m_st == M_IDLE || m_st == M_PLAY)) begin
      n1 = move(m_py1, u1, d1);
      n2 = move(m_py2, u2, d2);
    end
    case (m_st)
      M_IDLE: if (s) m_st = M_PLAY;
      M_PLAY: if (t) ball_tick();
      M_POINT: begin
        if (m_p1) m_s1 = (m_s1 < WIN) ? m_s1 + 1 : m_s1;
        else      m_s2 = (m_s2 < WIN) ? m_s2 + 1 : m_s2;
        m_bx = 460; m_by = 271; m_dx = m_p1; m_dy = 1;
        m_st = (m_s1 == WIN || m_s2 == WIN) ? M_OVER : M_IDLE;
      end
      default: if (s) begin m_s1 = 0; m_s2 = 0; m_st = M_IDLE; end
    endcase
    m_py1 = n1;
    m_py2 = n2;
  endtask

  function automatic logic [11:0] exp_rgb(input int h, input int v, input bit br);
    if (!br) return 12'h000;
    if (m_st != M_OVER && h >= m_bx && h < m_bx + SIZE && v >= m_by && v < m_by + SIZE)
      return 12'hF00;
    if ((h >= L_X0 && h <= L_X1 && v >= m_py1 - HALF && v <= m_py1 + HALF) ||
        (h >= R_X0 && h <= R_X1 && v >= m_py2 - HALF && v <= m_py2 + HALF))
      return 12'h0F0;
    if (h >= 318 && h <= 322 && v >= TOP && v <= BOTTOM) return 12'hFFF;
    return (m_st == M_OVER) ? 12'hF00 : 12'h00F;
  endfunction

  task automatic probe(input string tag, input int h, input int v, input bit br);
    hCount = 10'(h); vCount = 10'(v); bright = br;
    #1;
    chk(tag, {4'h0, rgb}, {4'h0, exp_rgb(h, v, br)});
    bright = 1'b1;
  endtask

  task automatic probe_const(input string tag, input int h, input int v, input logic [11:0] exp);
    hCount = 10'(h); vCount = 10'(v); bright = 1'b1;
    #1;
    chk(tag, {4'h0, rgb}, {4'h0, exp});
  endtask

  task automatic check_all();
    chk("score", score, {8'(m_s1), 8'(m_s2)});
    chk("game_over", {15'h0, game_over}, {15'h0, m_st == M_OVER});
    probe("ball_tl", m_bx, m_by, 1);
    probe("ball_br", m_bx + SIZE - 1, m_by + SIZE - 1, 1);
    probe("ball_left", m_bx - 1, m_by + 3, 1);
    probe("ball_right", m_bx + SIZE, m_by + 3, 1);
    probe("ball_above", m_bx + 3, m_by - 1, 1);
    probe("ball_below", m_bx + 3, m_by + SIZE, 1);
    probe("pad1_top", 160, m_py1 - HALF, 1);
    probe("pad1_above", 160, m_py1 - HALF - 1, 1);
    probe("pad1_bot", 160, m_py1 + HALF, 1);
    probe("pad1_below", 160, m_py1 + HALF + 1, 1);
    probe("pad2_top", 770, m_py2 - HALF, 1);
    probe("pad2_above", 770, m_py2 - HALF - 1, 1);
    probe("pad2_bot", 770, m_py2 + HALF, 1);
    probe("pad2_below", 770, m_py2 + HALF + 1, 1);
    probe("midline", 320, TOP, 1);
    probe("mid_out", 323, 200, 1);
    probe("dark", m_bx, m_by, 0);
  endtask

  task automatic cyc(input bit r, t, u1, d1, u2, d2, s);
    rst = r; tick = t; up1 = u1; down1 = d1; up2 = u2; down2 = d2; serve = s;
    model_update(r, t, u1, d1, u2, d2, s);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // mode 1 follows the ball, 2 runs from it, 3 follows with occasional random presses
  function automatic logic [1:0] pad_cmd(input int mode, input int py);
    int c;
    c = m_by + SIZE / 2;
    if (mode == 3 && ($urandom % 8) == 0) return 2'($urandom);
    if (mode == 1 || mode == 3) begin
      if (c < py - 1) return 2'b10;
      if (c > py + 1) return 2'b01;
      return 2'b00;
    end
    if (mode == 2) return (c < py) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic run_cycle(input int mode1, input int mode2, input bit allow_restart);
    logic [1:0] p1, p2;
    bit t, s;
    t  = ($urandom % 2) == 1;
    p1 = pad_cmd(mode1, m_py1);
    p2 = pad_cmd(mode2, m_py2);
    s  = 0;
    if (m_st == M_IDLE) begin
      if (($urandom % 4) == 0) begin s = 1; p1 = 2'b00; p2 = 2'b00; end
    end else if (m_st == M_OVER) begin
      s = allow_restart && (($urandom % 4) == 0);
    end else begin
      s = ($urandom % 16) == 0;
    end
    cyc(1, t, p1[1], p1[0], p2[1], p2[0], s);
  endtask

  initial begin
    // Reset wins over serve, tick and paddle inputs.
    cyc(0, 1, 1, 0, 0, 1, 1);
    chk("rst_score", score, 16'h0000);
    chk("rst_over", {15'h0, game_over}, 16'h0000);
    probe_const("rst_ball", 460, 271, 12'hF00);
    probe_const("rst_pad1", 160, 255, 12'h0F0);

    repeat (200) cyc(1, 1, 1, 0, 0, 1, 0);
    probe_const("clamp_p1_edge", 160, 34, 12'h0F0);
    probe_const("clamp_p1_out", 160, 33, 12'h00F);
    probe_const("clamp_p2_edge", 770, 516, 12'h0F0);
    repeat (3) cyc(1, 1, 1, 0, 0, 1, 0);
    probe_const("clamp_p1_hold", 160, 74, 12'h0F0);
    probe_const("clamp_p1_hold_out", 160, 75, 12'h00F);

    cyc(1, 1, 0, 0, 0, 0, 1);
    probe_const("serve_tick_still", 460, 271, 12'hF00);
    probe_const("serve_tick_left", 459, 271, 12'h00F);
    cyc(1, 1, 0, 0, 0, 0, 0);
    probe_const("first_move", 462, 273, 12'hF00);
    probe_const("first_move_left", 461, 273, 12'h00F);

    repeat (2000) run_cycle(3, 3, 1);

    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8000 && m_st != M_OVER; i++) run_cycle(1, 2, 0);
    chk("win_score", score, 16'h0700);
    chk("win_over", {15'h0, game_over}, 16'h0001);
    probe_const("over_bg", 400, 100, 12'hF00);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("restart_score", score, 16'h0000);
    chk("restart_over", {15'h0, game_over}, 16'h0000);
    probe_const("restart_bg", 400, 100, 12'h00F);

    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8000 && m_s2 < 2; i++) run_cycle(2, 1, 0);
    chk("p2_two", score, 16'h0002);
    for (int i = 0; i < 200 && m_st != M_PLAY; i++) run_cycle(2, 1, 0);
    repeat (10) run_cycle(2, 1, 0);
    cyc(0, 1, 1, 0, 1, 0, 1);
    chk("midplay_rst_score", score, 16'h0000);
    probe_const("midplay_rst_ball", 460, 271, 12'hF00);
    cyc(1, 1, 0, 0, 0, 0, 0);
    probe_const("midplay_rst_idle", 460, 271, 12'hF00);

    for (int i = 0; i < 8000 && m_st != M_POINT; i++) run_cycle(1, 2, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("midpoint_rst_score", score, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
